clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 42 ++++
 rtl/tick_gen.sv | 31 +++
 rtl/clock_set_ctrl.sv | 171 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: state encodings, digit width, BCD limits and the BCD increment
// helper shared by the clock/alarm setting controller.
`timescale 1ns/1ps
package clock_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } state_t;

  localparam int DIGIT_W = 8;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Packed two-digit BCD {tens, ones} plus one, wrapping to 00 past lim.
  // Anything at or above lim also lands on 00, so a field can never leave
  // its legal range through an increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int lim);
    logic [3:0] tens;
    logic [3:0] ones;
    int         val;
    tens = v[7:4];
    ones = v[3:0];
    val  = 10 * int'(tens) + int'(ones);
    if (val >= lim)
      bcd_inc = 8'h00;
    else if (ones == 4'd9)
      bcd_inc = {tens + 4'd1, 4'd0};
    else
      bcd_inc = {tens, ones + 4'd1};
  endfunction

  // One BCD nibble widened to an output digit field (upper nibble zero).
  function automatic logic [DIGIT_W-1:0] to_digit(input logic [3:0] n);
    to_digit = DIGIT_W'(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running 0..CLK_HZ-1 divider producing a one-cycle pulse
// on the terminal count; clr restarts the count from 0.
`timescale 1ns/1ps
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk_m,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Count up, wrap at terminal count, restart on clr.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clr || (r_cnt == CNT_MAX))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CNT_ONE;
  end

  assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: hh:mm:ss BCD clock with button-driven time setting.
// Optional alarm (hour/minute registers, two extra SET states and the
// alarm_hit comparator) is compiled in by defining CLOCK_ALARM_EN.
//
// state    | meaning
// RUN      | time advances one second per tick
// SET_HR   | inc edge bumps hour, time frozen
// SET_MIN  | inc edge bumps minute (no hour carry), time frozen
// SET_AHR  | inc edge bumps alarm hour   (CLOCK_ALARM_EN only)
// SET_AMIN | inc edge bumps alarm minute (CLOCK_ALARM_EN only)
`timescale 1ns/1ps
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic        clk_m,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [47:0] timestruct,
  output logic [2:0]  mode,
  output logic        tick,
  output logic        alarm_hit
);

  logic       r_mode_d;
  logic       r_inc_d;
  logic       w_mode_edge;
  logic       w_inc_edge;
  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_div_clr;
  logic       w_tick;
  logic [7:0] r_sec;
  logic [7:0] r_min;
  logic [7:0] r_hr;
  logic [7:0] w_sec_inc;
  logic [7:0] w_min_inc;
  logic [7:0] w_hr_inc;
  logic [7:0] w_run_sec;
  logic [7:0] w_run_min;
  logic [7:0] w_run_hr;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk_m (clk_m),
    .rst_n (rst_n),
    .clr   (w_div_clr),
    .tick  (w_tick)
  );

  // One delay stage per button for rising-edge detection.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_d <= 1'b0;
      r_inc_d  <= 1'b0;
    end else begin
      r_mode_d <= btn_mode;
      r_inc_d  <= btn_inc;
    end
  end

  assign w_mode_edge = btn_mode & ~r_mode_d;
  assign w_inc_edge  = btn_inc  & ~r_inc_d;

  // State register.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  // Mode-edge sequencing; the divider restarts whenever setting ends.
  always_comb begin
    w_state_nxt = r_state;
    w_div_clr   = 1'b0;
    if (w_mode_edge) begin
      case (r_state)
        RUN:      w_state_nxt = SET_HR;
        SET_HR:   w_state_nxt = SET_MIN;
`ifdef CLOCK_ALARM_EN
        SET_MIN:  w_state_nxt = SET_AHR;
        SET_AHR:  w_state_nxt = SET_AMIN;
        SET_AMIN: w_state_nxt = RUN;
`else
        SET_MIN:  w_state_nxt = RUN;
`endif
        default:  w_state_nxt = RUN;
      endcase
      w_div_clr = (r_state != RUN) && (w_state_nxt == RUN);
    end
  end

  assign w_sec_inc = bcd_inc(r_sec, SEC_MAX);
  assign w_min_inc = bcd_inc(r_min, MIN_MAX);
  assign w_hr_inc  = bcd_inc(r_hr,  HR_MAX);

  // Time after one second in RUN, with sec->min->hour carries.
  always_comb begin
    w_run_sec = w_sec_inc;
    w_run_min = r_min;
    w_run_hr  = r_hr;
    if (w_sec_inc == 8'h00) begin
      w_run_min = w_min_inc;
      if (w_min_inc == 8'h00)
        w_run_hr = w_hr_inc;
    end
  end

  // Time registers: a mode edge pre-empts both inc and tick in that cycle.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      r_sec <= 8'h00;
      r_min <= 8'h00;
      r_hr  <= 8'h00;
    end else if (w_mode_edge) begin
      if (r_state == RUN)
        r_sec <= 8'h00;
    end else begin
      case (r_state)
        RUN: begin
          if (w_tick) begin
            r_sec <= w_run_sec;
            r_min <= w_run_min;
            r_hr  <= w_run_hr;
          end
        end
        SET_HR:  if (w_inc_edge) r_hr  <= w_hr_inc;
        SET_MIN: if (w_inc_edge) r_min <= w_min_inc;
        default: ;
      endcase
    end
  end

`ifdef CLOCK_ALARM_EN
  logic [7:0] r_ahr;
  logic [7:0] r_amin;
  logic       r_alarm_hit;

  // Alarm edits plus a registered match on the time a RUN tick produces.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      r_ahr       <= 8'h00;
      r_amin      <= 8'h00;
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= (r_state == RUN) && w_tick && !w_mode_edge &&
                     (w_run_hr == r_ahr) && (w_run_min == r_amin) &&
                     (w_run_sec == 8'h00);
      if (!w_mode_edge && w_inc_edge) begin
        if (r_state == SET_AHR)
          r_ahr <= bcd_inc(r_ahr, HR_MAX);
        if (r_state == SET_AMIN)
          r_amin <= bcd_inc(r_amin, MIN_MAX);
      end
    end
  end

  assign alarm_hit = r_alarm_hit;
`else
  assign alarm_hit = 1'b0;
`endif

  assign timestruct = {to_digit(r_sec[3:0]), to_digit(r_sec[7:4]),
                       to_digit(r_min[3:0]), to_digit(r_min[7:4]),
                       to_digit(r_hr[3:0]),  to_digit(r_hr[7:4])};
  assign mode = r_state;
  assign tick = w_tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with CLK_HZ=4. Follows CLOCK_ALARM_EN
// so the same sequence covers both builds.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

`ifdef CLOCK_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic        clk_m = 1'b0;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_inc;
  logic [47:0] timestruct;
  logic [2:0]  mode;
  logic        tick;
  logic        alarm_hit;

  int n_pass  = 0;
  int n_total = 0;
  int n_ticks = 0;

  always #5 clk_m = ~clk_m;

  clock_set_ctrl #(.CLK_HZ(4)) dut (
    .clk_m      (clk_m),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .timestruct (timestruct),
    .mode       (mode),
    .tick       (tick),
    .alarm_hit  (alarm_hit)
  );

  function automatic logic [47:0] ts(input int h, input int m, input int s);
    ts = {8'(s % 10), 8'(s / 10), 8'(m % 10), 8'(m / 10), 8'(h % 10), 8'(h / 10)};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_m);
      #1;
    end
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1);
    btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      btn_inc = 1'b1; cyc(1);
      btn_inc = 1'b0; cyc(1);
    end
  endtask

  // From SET_MIN back to RUN; the last edge clears the divider.
  task automatic exit_from_min();
    press_mode();
    if (ALARM) begin
      press_mode();
      press_mode();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(2);
    chk("rst_time", timestruct, ts(0, 0, 0));
    chk("rst_mode", 48'(mode), 48'd0);
    chk("rst_tick", 48'(tick), 48'd0);
    chk("rst_alarm", 48'(alarm_hit), 48'd0);

    // 240 cycles of RUN from reset release: 60 ticks, period 4
    rst_n = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      cyc(1);
      if (tick) n_ticks++;
      chk("tick_phase", 48'(tick), 48'((i % 4) == 3));
      chk("alarm_idle", 48'(alarm_hit), 48'd0);
    end
    chk("tick_count", 48'(n_ticks), 48'd60);
    chk("run_60s", timestruct, ts(0, 1, 0));

    // Preload 23:59 through the SET states
    press_mode();
    chk("set_hr_mode", 48'(mode), 48'd1);
    press_inc(23);
    chk("hr_23", timestruct, ts(23, 1, 0));
    press_mode();
    chk("set_min_mode", 48'(mode), 48'd2);
    press_inc(58);
    chk("min_59", timestruct, ts(23, 59, 0));
    // mode and inc together: mode wins, minute holds at 59
    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; cyc(1);
    chk("both_mode", 48'(mode), ALARM ? 48'd3 : 48'd0);
    chk("both_min", timestruct, ts(23, 59, 0));
    if (ALARM) begin
      press_mode();
      press_mode();
    end
    chk("back_run", 48'(mode), 48'd0);
    cyc(231);
    chk("t_235958", timestruct, ts(23, 59, 58));
    cyc(4);
    chk("t_235959", timestruct, ts(23, 59, 59));
    cyc(3);
    chk("tick_before_wrap", 48'(tick), 48'd1);
    chk("alarm_before_wrap", 48'(alarm_hit), 48'd0);
    cyc(1);
    chk("t_wrap", timestruct, ts(0, 0, 0));
    chk("alarm_at_midnight", 48'(alarm_hit), ALARM ? 48'd1 : 48'd0);
    cyc(1);
    chk("alarm_one_cycle", 48'(alarm_hit), 48'd0);

    // Build 10:20:35, then enter SET_HR on a coinciding tick
    press_mode();
    press_inc(10);
    press_mode();
    press_inc(20);
    exit_from_min();
    cyc(139);
    chk("t_102035", timestruct, ts(10, 20, 35));
    cyc(3);
    chk("tick_at_mode", 48'(tick), 48'd1);
    btn_mode = 1'b1; cyc(1);
    btn_mode = 1'b0;
    chk("enter_hr_mode", 48'(mode), 48'd1);
    chk("enter_hr_sec0", timestruct, ts(10, 20, 0));
    cyc(20);
    chk("set_frozen", timestruct, ts(10, 20, 0));
    press_inc(14);
    chk("hr_wrap_path", timestruct, ts(0, 20, 0));
    // held button counts once
    btn_inc = 1'b1; cyc(3);
    btn_inc = 1'b0; cyc(1);
    chk("hr_01", timestruct, ts(1, 20, 0));
    press_mode();
    exit_from_min();
    chk("run_after_set", 48'(mode), 48'd0);
    chk("time_after_set", timestruct, ts(1, 20, 0));

    // Reset mid-SET_MIN at 07:45
    press_mode();
    press_inc(6);
    press_mode();
    press_inc(25);
    chk("t_0745", timestruct, ts(7, 45, 0));
    chk("mode_min", 48'(mode), 48'd2);
    rst_n = 1'b0;
    #2;
    chk("async_rst_time", timestruct, ts(0, 0, 0));
    chk("async_rst_mode", 48'(mode), 48'd0);
    @(posedge clk_m); #1;
    rst_n = 1'b1;

    if (ALARM) begin
      // Alarm 00:01 from 00:00:00
      press_mode();
      press_mode();
      press_mode();
      chk("ahr_mode", 48'(mode), 48'd3);
      chk("ahr_time_kept", timestruct, ts(0, 0, 0));
      press_mode();
      chk("amin_mode", 48'(mode), 48'd4);
      press_inc(1);
      chk("amin_time_kept", timestruct, ts(0, 0, 0));
      press_mode();
      chk("alarm_run", 48'(mode), 48'd0);
      cyc(238);
      chk("t_59s", timestruct, ts(0, 0, 59));
      chk("tick_60th", 48'(tick), 48'd1);
      chk("alarm_pre", 48'(alarm_hit), 48'd0);
      cyc(1);
      chk("t_0100", timestruct, ts(0, 1, 0));
      chk("alarm_hit", 48'(alarm_hit), 48'd1);
      cyc(1);
      chk("alarm_drop", 48'(alarm_hit), 48'd0);
    end else begin
      for (int i = 1; i <= 240; i++) begin
        cyc(1);
        chk("alarm_tied", 48'(alarm_hit), 48'd0);
      end
      chk("t_0100", timestruct, ts(0, 1, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
